// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared constants and FSM state type for the nibble-serial adder
package cla_seq_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/cla.sv
// cla: 4-bit carry-look-ahead adder slice
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cy;

    assign g = a & b;
    assign p = a ^ b;
    assign cy[0] = c0;
    assign cy[1] = g[0] | (p[0] & c0);
    assign cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    assign cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c0);
    assign s = p ^ cy[3:0];
    assign c = cy[4];
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: wide adder that time-shares one 4-bit CLA across operand nibbles
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    input  logic                         cin,
    output logic [NIBBLE_W*NIBBLES-1:0]  sum,
    output logic                         cout,
    output logic                         done,
    output logic                         busy
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [IW+1:0] sh;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    s;
    logic          c;
    logic          last;

    // bit offset of the current nibble is idx*4
    assign sh    = {idx, 2'b00};
    assign a_nib = 4'(a_reg >> sh);
    assign b_nib = 4'(b_reg >> sh);
    assign last  = idx == IW'(NIBBLES - 1);

    assign start_ready = state == IDLE;
    assign busy        = (state == RUN) || (state == DONE);

    cla u_cla (
        .a  (a_nib),
        .b  (b_nib),
        .c0 (carry),
        .s  (s),
        .c  (c)
    );

    // sequencer: capture operands on accept, fold one nibble per RUN cycle, pulse done
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start_valid) begin
                    a_reg <= a;
                    b_reg <= b;
                    carry <= cin;
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum   <= (sum & ~(W'(4'hF) << sh)) | (W'(s) << sh);
                    carry <= c;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout  <= c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-word adder sequencer that shares the team's single 4-bit carry-look-ahead adder (`CLA`) across the nibbles of a wide operand pair. It takes one start request at a time and feeds one nibble pair plus the running carry to the `CLA` each cycle. It assembles the wide sum and the final carry-out, then signals completion with a one-cycle `done` pulse. It serves datapaths that need wide additions without replicating adder hardware.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Total operand width W = 4*NIBBLES. Legal range 1..16.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start_valid`  in  1  request to begin an addition.
- `start_ready`  out  1  block can accept a request.
- `a`  in  W  operand A; sampled only on accept.
- `b`  in  W  operand B; sampled only on accept.
- `cin`  in  1  carry-in; sampled only on accept.
- `sum`  out  W  registered result.
- `cout`  out  1  registered final carry-out.
- `done`  out  1  one-cycle pulse: `sum`/`cout` are updated and valid.
- `busy`  out  1  high while in RUN or DONE.

## Operation
- **Accept:** a request is accepted on a rising edge where `start_valid && start_ready`. On accept, `a`, `b`, `cin` are captured into internal registers. Later changes on these inputs have no effect on the in-flight operation.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `start_ready`=1, `busy`=0.
  - On accept: `idx`<=0, `carry`<=`cin`, go to RUN.
  - Without accept: stay in IDLE.
- **RUN:**
  - `start_ready`=0, `busy`=1.
  - The `CLA` is driven with `a_reg[4*idx+:4]`, `b_reg[4*idx+:4]` and `carry`.
  - Each cycle: `sum[4*idx+:4]`<=`s`, `carry`<=`c`, `idx`<=`idx`+1.
  - When `idx`==NIBBLES-1: also `cout`<=`c`, then go to DONE.
- **DONE:**
  - `done`=1 for exactly this cycle; `busy`=1, `start_ready`=0.
  - Unconditionally go to IDLE.
- **Result hold:** `sum` and `cout` hold their values until the next accepted operation begins overwriting them. The low nibble of `sum` changes in the first RUN cycle.
- **Arithmetic:** result is modulo 2^W, with `cout` = bit W of `a`+`b`+`cin`. `idx` width is max(1, $clog2(NIBBLES)).
- **Requests while not ready:** `start_valid` in RUN or DONE is ignored and not queued. The requester must hold `start_valid` until it sees `start_ready`.
- **Reset:** `rst` in any state (including mid-RUN) takes effect on the next edge and the in-flight operation is discarded.
  - State returns to IDLE.
  - `sum`=0, `cout`=0, `done`=0, `busy`=0, `start_ready`=1.
  - Internal `idx`, `carry`, `a_reg`, `b_reg` are cleared.
  - `rst` has priority over accept in the same cycle.

## Timing
- Accept at edge T → RUN cycles T+1 .. T+NIBBLES → `done` high in cycle T+NIBBLES+1.
- Latency from accept to `done` is NIBBLES+1 cycles (5 for the default).
- Earliest next accept is at edge T+NIBBLES+2, so throughput is one op per NIBBLES+2 cycles.
- `start_ready` and `busy` are decoded from registered state, with no combinational path from `start_valid`.
- `done`, `sum` and `cout` are registered outputs.
- The `CLA` sits combinationally between the operand/carry registers and the `sum`/`carry` registers, so there is one `CLA` delay per cycle.

## Structure
- **Package `cla_seq_pkg`:**
  - `NIBBLE_W` = 4.
  - State typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Any illegal state encoding recovers to IDLE.
- **Sub-module:** exactly one instance of the existing 4-bit `CLA` (ports a, b, c0, s, c). No other sub-modules; the FSM, counter and registers live in `cla_seq_adder`.

## Test plan
- Reset: assert `rst` for 2 cycles → `sum`=0x0000, `cout`=0, `done`=0, `busy`=0, `start_ready`=1.
- 0x1234 + 0x4321, `cin`=0, accept at T → `done` at T+5 only, `sum`=0x5555, `cout`=0.
- Carry ripple across all nibbles:
  - 0xFFFF + 0x0001, `cin`=0 → `sum`=0x0000, `cout`=1.
  - 0xFFFF + 0xFFFF, `cin`=1 → `sum`=0xFFFF, `cout`=1.
- Input isolation and back-to-back operation:
  - Hold `start_valid`=1 with new operands (0x00FF + 0x0F0F) during RUN/DONE → ignored while busy.
  - The first result is unaffected.
  - The second op is accepted at T+6 and `done` fires at T+11 with `sum`=0x100E, `cout`=0.
- Reset mid-operation: assert `rst` in the 2nd RUN cycle → next cycle IDLE with all outputs at reset values and no `done`. A subsequent 0x8000 + 0x8000 gives `sum`=0x0000, `cout`=1.
- NIBBLES=1 build: 0xF + 0x1, `cin`=0 → `done` at T+2, `sum`=0x0, `cout`=1.
